// File: rtl/carry_lookahead_adder_controller.sv
// Operand sequencer and result capture for the carry-lookahead adder datapath.
// Loads A then B from the shared bus and holds {carry_out,sum} on a valid/ready port.
module carry_lookahead_adder_controller #(
  parameter int N     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N:0]       dp_sum,
  output logic             clr_a,
  output logic             clr_b,
  output logic             load_a,
  output logic             load_b,
  output logic             carry_in,
  output logic [N:0]       result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD_A,
    LOAD_B,
    ADD,
    OUT
  } state_t;

  state_t state, state_nx;
  logic   take_cin;
  logic   clr_st;
  logic   ld_a_st;
  logic   ld_b_st;
  logic   rdy_st;
  logic   done;

  always_comb begin
    state_nx  = state;
    take_cin  = 1'b0;
    clr_st    = 1'b0;
    ld_a_st   = 1'b0;
    ld_b_st   = 1'b0;
    rdy_st    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          take_cin = 1'b1;
          state_nx = CLR;
        end
      end
      CLR: begin
        clr_st   = 1'b1;
        state_nx = LOAD_A;
      end
      LOAD_A: begin
        rdy_st  = 1'b1;
        ld_a_st = in_valid;
        if (in_valid) state_nx = LOAD_B;
      end
      LOAD_B: begin
        rdy_st  = 1'b1;
        ld_b_st = in_valid;
        if (in_valid) state_nx = ADD;
      end
      ADD: begin
        state_nx = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done = 1'b1;
          if (start) begin
            take_cin = 1'b1;
            state_nx = CLR;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Reset clears the datapath on the same edge and blocks any load.
  assign clr_a    = clr_st | rst;
  assign clr_b    = clr_st | rst;
  assign load_a   = ld_a_st & ~rst;
  assign load_b   = ld_b_st & ~rst;
  assign in_ready = rdy_st & ~rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      result   <= '0;
      carry_in <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nx;
      if (take_cin) carry_in <= cin;
      if (state == ADD) result <= dp_sum;
      if (done) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_carry_lookahead_adder_controller.sv
// Bench for the adder controller with a behavioural datapath model
// and a queue of expected sums checked as results appear.
module tb_carry_lookahead_adder_controller;

  localparam int N     = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             cin;
  logic             in_valid;
  logic             in_ready;
  logic [N:0]       dp_sum;
  logic             clr_a;
  logic             clr_b;
  logic             load_a;
  logic             load_b;
  logic             carry_in;
  logic [N:0]       result;
  logic             out_valid;
  logic             out_ready;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  logic [N-1:0]     data_in;
  logic [N-1:0]     dp_a;
  logic [N-1:0]     dp_b;

  int               n_cmp = 0;
  int               n_mis = 0;
  int               cyc   = 0;
  logic [N:0]       exp_q[$];
  logic [CNT_W-1:0] exp_count;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (clr_a) dp_a <= '0;
    else if (load_a) dp_a <= data_in;
    if (clr_b) dp_b <= '0;
    else if (load_b) dp_b <= data_in;
  end

  assign dp_sum = {1'b0, dp_a} + {1'b0, dp_b} + {{N{1'b0}}, carry_in};

  carry_lookahead_adder_controller #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cin       (cin),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dp_sum    (dp_sum),
    .clr_a     (clr_a),
    .clr_b     (clr_b),
    .load_a    (load_a),
    .load_b    (load_b),
    .carry_in  (carry_in),
    .result    (result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .op_count  (op_count)
  );

  function automatic logic [N:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic send_start(input logic c);
    start = 1'b1;
    cin   = c;
    @(negedge clk);
    start = 1'b0;
    cin   = ~c;
  endtask

  task automatic feed(input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic c, input int gap, output bit ok);
    ok       = 1'b0;
    data_in  = a;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    if (!in_ready) return;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    data_in = b;
    @(negedge clk);
    exp_q.push_back({1'b0, a} + {1'b0, b} + {{N{1'b0}}, c});
    ok = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    for (int k = 0; k < 40 && !out_valid; k++) @(negedge clk);
    ok = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cin = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; data_in = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({in_ready, load_a, load_b, out_valid, busy, carry_in} !== 6'b0) begin
      n_mis++;
      $display("FAIL reset_ctl: got %b want 000000",
               {in_ready, load_a, load_b, out_valid, busy, carry_in});
    end
    n_cmp++;
    if ({clr_a, clr_b} !== 2'b11) begin
      n_mis++;
      $display("FAIL reset_clr: got %b want 11", {clr_a, clr_b});
    end
    n_cmp++;
    if (result !== '0 || op_count !== '0) begin
      n_mis++;
      $display("FAIL reset_regs: got result %h count %h want 0 0", result, op_count);
    end
    n_cmp++;
    if (dp_a !== '0 || dp_b !== '0) begin
      n_mis++;
      $display("FAIL reset_dp: got A %h B %h want 0 0", dp_a, dp_b);
    end
    rst = 1'b0;
    exp_count = '0;
    @(negedge clk);
    n_cmp++;
    if (clr_a !== 1'b0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL idle_after_reset: got clr %b busy %b want 0 0", clr_a, busy);
    end
  endtask

  task automatic run_single(input string nm, input logic [N-1:0] a,
                            input logic [N-1:0] b, input logic c,
                            input int gap, input int lat_exp);
    int         t0;
    bit         ok;
    logic [N:0] e;
    t0 = cyc;
    send_start(c);
    feed(a, b, c, gap, ok);
    if (ok) wait_valid(ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL %s_timeout: got no out_valid want out_valid", nm);
    end
    n_cmp++;
    if (cyc - t0 !== lat_exp) begin
      n_mis++;
      $display("FAIL %s_latency: got %0d want %0d", nm, cyc - t0, lat_exp);
    end
    e = pop_exp();
    n_cmp++;
    if (result !== e) begin
      n_mis++;
      $display("FAIL %s_result: got %h want %h", nm, result, e);
    end
    @(negedge clk);
    exp_count++;
    n_cmp++;
    if (op_count !== exp_count || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL %s_done: got count %h valid %b busy %b want %h 0 0",
               nm, op_count, out_valid, busy, exp_count);
    end
  endtask

  task automatic test_basic();
    run_single("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 0, 5);
    n_cmp++;
    if (result !== 17'h10000) begin
      n_mis++;
      $display("FAIL ffff_plus_1_const: got %h want 10000", result);
    end
  endtask

  task automatic test_in_stall();
    run_single("in_stall", 16'h1234, 16'h4321, 1'b1, 3, 8);
    n_cmp++;
    if (result !== 17'h05556) begin
      n_mis++;
      $display("FAIL in_stall_const: got %h want 05556", result);
    end
  endtask

  task automatic test_back_to_back();
    bit         ok;
    logic [N:0] r0;
    logic [N:0] e;
    send_start(1'b1);
    feed(16'h00FF, 16'h0F01, 1'b1, 0, ok);
    if (ok) wait_valid(ok);
    n_cmp++;
    if (!ok) begin
      n_mis++;
      $display("FAIL hold_timeout: got no out_valid want out_valid");
    end
    e = pop_exp();
    n_cmp++;
    if (result !== e) begin
      n_mis++;
      $display("FAIL hold_result: got %h want %h", result, e);
    end
    r0 = result;
    out_ready = 1'b0;
    start     = 1'b1;
    cin       = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== r0 || clr_a !== 1'b0) begin
        n_mis++;
        $display("FAIL hold_cycle%0d: got valid %b result %h clr %b want 1 %h 0",
                 k, out_valid, result, clr_a, r0);
      end
    end
    out_ready = 1'b1;
    send_start(1'b0);
    exp_count++;
    n_cmp++;
    if (clr_a !== 1'b1 || out_valid !== 1'b0 || op_count !== exp_count) begin
      n_mis++;
      $display("FAIL b2b_clr: got clr %b valid %b count %h want 1 0 %h",
               clr_a, out_valid, op_count, exp_count);
    end
    feed(16'hAAAA, 16'h5555, 1'b0, 0, ok);
    n_cmp++;
    if (carry_in !== 1'b0) begin
      n_mis++;
      $display("FAIL b2b_cin: got %b want 0", carry_in);
    end
    if (ok) wait_valid(ok);
    e = pop_exp();
    n_cmp++;
    if (!ok || result !== e || result !== 17'h0FFFF) begin
      n_mis++;
      $display("FAIL b2b_result: got %h want %h", result, e);
    end
    @(negedge clk);
    exp_count++;
    n_cmp++;
    if (op_count !== exp_count) begin
      n_mis++;
      $display("FAIL b2b_count: got %h want %h", op_count, exp_count);
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = '0;
    send_start(1'b1);
    data_in  = 16'h7777;
    in_valid = 1'b0;
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    data_in = 16'h1111;
    rst     = 1'b1;
    #1;
    n_cmp++;
    if (clr_a !== 1'b1 || clr_b !== 1'b1 || load_b !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_gate: got clr %b%b load_b %b want 11 0",
               clr_a, clr_b, load_b);
    end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || op_count !== exp_count) begin
      n_mis++;
      $display("FAIL abort_idle: got busy %b valid %b count %h want 0 0 %h",
               busy, out_valid, op_count, exp_count);
    end
    n_cmp++;
    if (dp_a !== '0 || dp_b !== '0) begin
      n_mis++;
      $display("FAIL abort_dp: got A %h B %h want 0 0", dp_a, dp_b);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || exp_q.size() !== 0) begin
      n_mis++;
      $display("FAIL abort_quiet: got valid %b queued %0d want 0 0",
               out_valid, exp_q.size());
    end
    run_single("after_abort", 16'h8000, 16'h8000, 1'b0, 0, 5);
    n_cmp++;
    if (result !== 17'h10000) begin
      n_mis++;
      $display("FAIL after_abort_const: got %h want 10000", result);
    end
  endtask

  task automatic test_wrap();
    bit               ok;
    bit               saw_wrap;
    logic [CNT_W-1:0] prev;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             c;
    logic [N:0]       e;
    int               last_v;
    saw_wrap = 1'b0;
    prev     = op_count;
    last_v   = 0;
    for (int i = 0; i < 256; i++) begin
      a = N'($urandom);
      b = N'($urandom);
      c = 1'($urandom_range(0, 1));
      send_start(c);
      if (i > 0) begin
        exp_count++;
        n_cmp++;
        if (op_count !== exp_count) begin
          n_mis++;
          $display("FAIL wrap_count%0d: got %h want %h", i, op_count, exp_count);
        end
        if (prev === 8'hFF && op_count === 8'h00) saw_wrap = 1'b1;
        prev = op_count;
      end
      feed(a, b, c, 0, ok);
      if (ok) wait_valid(ok);
      e = pop_exp();
      n_cmp++;
      if (!ok || result !== e) begin
        n_mis++;
        $display("FAIL wrap_result%0d: got %h want %h", i, result, e);
      end
      if (i > 0) begin
        n_cmp++;
        if (cyc - last_v !== 5) begin
          n_mis++;
          $display("FAIL wrap_rate%0d: got %0d want 5", i, cyc - last_v);
        end
      end
      last_v = cyc;
    end
    @(negedge clk);
    exp_count++;
    n_cmp++;
    if (op_count !== exp_count || busy !== 1'b0) begin
      n_mis++;
      $display("FAIL wrap_final: got count %h busy %b want %h 0",
               op_count, busy, exp_count);
    end
    n_cmp++;
    if (!saw_wrap) begin
      n_mis++;
      $display("FAIL wrap_seen: got no ff->00 want ff->00");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_in_stall();
    test_back_to_back();
    test_reset_abort();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
